tag_mem_assoc: RTL and testbench

Parametrised N-way set-associative tag memory for the L1 data cache. It is the successor to the direct-mapped tag store. It performs a same-cycle tag compare across all ways and selects a replacement victim (first invalid way, else tree pseudo-LRU). It invalidates the whole array by a one-set-per-cycle sweep after reset or on flush. It sits between the cache controller FSM and the data memory, and supplies hit/way/victim information each cycle.

---
 rtl/tag_mem_assoc_pkg.sv | 13 +
 rtl/tag_mem_assoc_plru_tree.sv | 44 ++++
 rtl/tag_mem_assoc.sv | 163 ++++++++++++++++
 tb/tb_tag_mem_assoc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_mem_assoc_pkg.sv
// Shared types for the set-associative tag store: sweep FSM state and way-index width helper.
package tag_mem_assoc_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } sweep_state_e;

  function automatic int way_idx_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/tag_mem_assoc_plru_tree.sv
// Tree pseudo-LRU: victim walk over the lookup set's bits and next-bits for a touched way.
module plru_tree
  import tag_mem_assoc_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int WAY_W  = way_idx_w(WAYS),
  parameter int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [PLRU_W-1:0] lru_bits_i,
  output logic [WAY_W-1:0]  victim_way_o,
  input  logic [PLRU_W-1:0] touch_bits_i,
  input  logic [WAY_W-1:0]  touch_way_i,
  output logic [PLRU_W-1:0] touch_bits_o
);

  localparam int LEVELS = $clog2(WAYS);

  // Nodes are heap-ordered: level l, position p lives at bit (2^l - 1 + p).
  always_comb begin
    int prefix;
    int step;
    prefix = 0;
    step   = 0;
    for (int l = 0; l < LEVELS; l++) begin
      step = 0;
      for (int p = 0; p < (1 << l); p++) begin
        if (prefix == p) step = int'(lru_bits_i[(1 << l) - 1 + p]);
      end
      prefix = 2 * prefix + step;
    end
    victim_way_o = WAY_W'(prefix);
  end

  always_comb begin
    touch_bits_o = touch_bits_i;
    for (int l = 0; l < LEVELS; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((int'(touch_way_i) >> (LEVELS - l)) == p)
          touch_bits_o[(1 << l) - 1 + p] = ~touch_way_i[LEVELS - 1 - l];
      end
    end
  end

endmodule

// File: rtl/tag_mem_assoc.sv
// N-way set-associative tag store with same-cycle lookup, PLRU victim and invalidate sweep.
// Optional per-way dirty bit enabled by defining TAG_MEM_DIRTY_EN.
module tag_mem_assoc
  import tag_mem_assoc_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 20,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = way_idx_w(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             ready_o,
  input  logic [IDX_W-1:0] req_index_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             hit_o,
  output logic [WAY_W-1:0] hit_way_o,
  output logic [WAY_W-1:0] victim_way_o,
  output logic             victim_valid_o,
  output logic [TAG_W-1:0] victim_tag_o,
`ifdef TAG_MEM_DIRTY_EN
  output logic             victim_dirty_o,
  input  logic             wr_dirty_i,
`endif
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [WAY_W-1:0] wr_way_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_valid_i,
  input  logic             touch_en_i,
  input  logic [IDX_W-1:0] touch_index_i,
  input  logic [WAY_W-1:0] touch_way_i
);

  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef struct packed {
    logic             valid;
`ifdef TAG_MEM_DIRTY_EN
    logic             dirty;
`endif
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t            mem_q  [SETS][WAYS];
  logic [PLRU_W-1:0] plru_q [SETS];

  sweep_state_e      state_q, state_d;
  logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
  logic              ready_q, ready_d;

  logic              wr_fire, touch_fire;
  logic [PLRU_W-1:0] plru_touched;
  logic [WAY_W-1:0]  plru_victim;
  logic              hit_any, inv_any;
  logic [WAY_W-1:0]  hit_idx, inv_idx, vic_way;
  entry_t            vic_entry;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    ready_d     = ready_q;
    case (state_q)
      ST_SWEEP: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(SETS - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (flush_i) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
          ready_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ready_q     <= ready_d;
    end
  end

  // A flush takes priority: updates presented in the flush cycle are dropped.
  assign wr_fire    = wr_en_i & ready_q & ~flush_i;
  assign touch_fire = touch_en_i & ready_q & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (state_q == ST_SWEEP) begin
      for (int w = 0; w < WAYS; w++) begin
        mem_q[sweep_idx_q][w].valid <= 1'b0;
`ifdef TAG_MEM_DIRTY_EN
        mem_q[sweep_idx_q][w].dirty <= 1'b0;
`endif
      end
      plru_q[sweep_idx_q] <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_index_i][wr_way_i].valid <= wr_valid_i;
        mem_q[wr_index_i][wr_way_i].tag   <= wr_tag_i;
`ifdef TAG_MEM_DIRTY_EN
        mem_q[wr_index_i][wr_way_i].dirty <= wr_dirty_i;
`endif
      end
      if (touch_fire) plru_q[touch_index_i] <= plru_touched;
    end
  end

  plru_tree #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W),
    .PLRU_W(PLRU_W)
  ) u_plru (
    .lru_bits_i  (plru_q[req_index_i]),
    .victim_way_o(plru_victim),
    .touch_bits_i(plru_q[touch_index_i]),
    .touch_way_i (touch_way_i),
    .touch_bits_o(plru_touched)
  );

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem_q[req_index_i][w].valid && (mem_q[req_index_i][w].tag == req_tag_i)) begin
        hit_any = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!mem_q[req_index_i][w].valid) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(w);
      end
    end
  end

  assign vic_way   = inv_any ? inv_idx : plru_victim;
  assign vic_entry = mem_q[req_index_i][vic_way];

  assign ready_o        = ready_q;
  assign hit_o          = ready_q & hit_any;
  assign hit_way_o      = ready_q ? hit_idx : '0;
  assign victim_way_o   = ready_q ? vic_way : '0;
  assign victim_valid_o = ready_q & vic_entry.valid;
  assign victim_tag_o   = vic_entry.tag;
`ifdef TAG_MEM_DIRTY_EN
  assign victim_dirty_o = ready_q & vic_entry.valid & vic_entry.dirty;
`endif

endmodule

// File: tb/tb_tag_mem_assoc.sv
// Randomised + directed bench for tag_mem_assoc (WAYS=4, SETS=16, TAG_W=20) against a timestamp PLRU model.
module tb_tag_mem_assoc;

  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int TAG_W = 20;
  localparam int IDX_W = 4;
  localparam int WAY_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             ready_o;
  logic [IDX_W-1:0] req_index_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             hit_o;
  logic [WAY_W-1:0] hit_way_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             victim_valid_o;
  logic [TAG_W-1:0] victim_tag_o;
  logic             wr_en_i = 1'b0;
  logic [IDX_W-1:0] wr_index_i = '0;
  logic [WAY_W-1:0] wr_way_i = '0;
  logic [TAG_W-1:0] wr_tag_i = '0;
  logic             wr_valid_i = 1'b0;
  logic             touch_en_i = 1'b0;
  logic [IDX_W-1:0] touch_index_i = '0;
  logic [WAY_W-1:0] touch_way_i = '0;
`ifdef TAG_MEM_DIRTY_EN
  logic             wr_dirty_i = 1'b0;
  logic             victim_dirty_o;
`endif

  tag_mem_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .ready_o(ready_o),
    .req_index_i(req_index_i), .req_tag_i(req_tag_i),
    .hit_o(hit_o), .hit_way_o(hit_way_o),
    .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o), .victim_tag_o(victim_tag_o),
`ifdef TAG_MEM_DIRTY_EN
    .victim_dirty_o(victim_dirty_o), .wr_dirty_i(wr_dirty_i),
`endif
    .wr_en_i(wr_en_i), .wr_index_i(wr_index_i), .wr_way_i(wr_way_i),
    .wr_tag_i(wr_tag_i), .wr_valid_i(wr_valid_i),
    .touch_en_i(touch_en_i), .touch_index_i(touch_index_i), .touch_way_i(touch_way_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: contents per entry plus a last-touch timestamp per way.
  bit             m_valid [SETS][WAYS];
  bit [TAG_W-1:0] m_tag   [SETS][WAYS];
  bit             m_dirty [SETS][WAYS];
  int             m_ts    [SETS][WAYS];
  int             m_time;
  bit             m_ready;
  int             m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Each tree node points away from whichever side was touched most recently.
  function automatic int m_victim(input int s);
    int lo, hi;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    lo = max2(m_ts[s][0], m_ts[s][1]);
    hi = max2(m_ts[s][2], m_ts[s][3]);
    if (lo > hi) return (m_ts[s][2] > m_ts[s][3]) ? 3 : 2;
    return (m_ts[s][0] > m_ts[s][1]) ? 1 : 0;
  endfunction

  task automatic m_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic m_edge();
    if (!rst_ni) return;
    if (!m_ready) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[m_cnt][w] = 1'b0;
        m_dirty[m_cnt][w] = 1'b0;
        m_ts[m_cnt][w]    = 0;
      end
      if (m_cnt == SETS - 1) m_ready = 1'b1;
      m_cnt = (m_cnt + 1) % SETS;
    end else if (flush_i) begin
      m_reset();
    end else begin
      if (wr_en_i) begin
        m_valid[wr_index_i][wr_way_i] = wr_valid_i;
        m_tag[wr_index_i][wr_way_i]   = wr_tag_i;
`ifdef TAG_MEM_DIRTY_EN
        m_dirty[wr_index_i][wr_way_i] = wr_dirty_i;
`endif
      end
      if (touch_en_i) begin
        m_time++;
        m_ts[touch_index_i][touch_way_i] = m_time;
      end
    end
  endtask

  task automatic check_outputs();
    int s, v, exp_way;
    bit exp_hit;
    s = int'(req_index_i);
    exp_hit = 1'b0;
    exp_way = 0;
    chk("ready", ready_o, m_ready);
    if (m_ready)
      for (int w = 0; w < WAYS; w++)
        if (!exp_hit && m_valid[s][w] && m_tag[s][w] == req_tag_i) begin
          exp_hit = 1'b1;
          exp_way = w;
        end
    chk("hit", hit_o, exp_hit);
    chk("hit_way", hit_way_o, exp_way);
    v = m_ready ? m_victim(s) : 0;
    chk("victim_way", victim_way_o, v);
    chk("victim_valid", victim_valid_o, m_ready && m_valid[s][v]);
    if (m_ready && m_valid[s][v]) chk("victim_tag", victim_tag_o, m_tag[s][v]);
`ifdef TAG_MEM_DIRTY_EN
    chk("victim_dirty", victim_dirty_o, m_ready && m_valid[s][v] && m_dirty[s][v]);
`endif
  endtask

  // Called just after a rising edge; checks outputs, advances the model, waits for the next edge.
  task automatic cyc();
    #1;
    check_outputs();
    m_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int s, input int w, input int tag, input bit valid, input bit dirty);
    wr_en_i = 1'b1; wr_index_i = IDX_W'(s); wr_way_i = WAY_W'(w);
    wr_tag_i = TAG_W'(tag); wr_valid_i = valid;
`ifdef TAG_MEM_DIRTY_EN
    wr_dirty_i = dirty;
`else
    if (dirty) wr_valid_i = valid;
`endif
    cyc();
    wr_en_i = 1'b0;
  endtask

  task automatic touch(input int s, input int w);
    touch_en_i = 1'b1; touch_index_i = IDX_W'(s); touch_way_i = WAY_W'(w);
    cyc();
    touch_en_i = 1'b0;
  endtask

  task automatic count_sweep(input int flush_at, output int n);
    n = 0;
    while (!ready_o && n < 64) begin
      flush_i = (n == flush_at);
      cyc();
      n++;
    end
    flush_i = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst_ni = 1'b0;
    m_reset();
    repeat (hold) cyc();
    rst_ni = 1'b1;
  endtask

  initial begin
    int n;
    m_time = 0;
    m_reset();
    @(posedge clk_i); #1;

    do_reset(2);
    count_sweep(-1, n);
    chk("reset_sweep_len", n, 16);

    // write then hit, including read-during-write
    req_index_i = 4'd5; req_tag_i = 20'hABCDE;
    wr_en_i = 1'b1; wr_index_i = 4'd5; wr_way_i = 2'd2; wr_tag_i = 20'hABCDE; wr_valid_i = 1'b1;
    #1 chk("rdw_old_miss", hit_o, 0);
    cyc();
    wr_en_i = 1'b0;
    #1 chk("hit_after_wr", hit_o, 1);
    chk("hit_way_after_wr", hit_way_o, 2);
    req_tag_i = 20'hABCDF;
    #1 chk("miss_neighbor_tag", hit_o, 0);
    cyc();

    // PLRU order on set 3
    for (int w = 0; w < WAYS; w++) wr(3, w, 'h300 + w, 1'b1, 1'b0);
    for (int w = 0; w < WAYS; w++) touch(3, w);
    req_index_i = 4'd3;
    #1 chk("plru_after_0123", victim_way_o, 0);
    touch(3, 0);
    #1 chk("plru_after_0", victim_way_o, 2);
    chk("plru_victim_valid", victim_valid_o, 1);
    cyc();

    // invalid-first on set 7
    wr(7, 0, 'h700, 1'b1, 1'b0);
    wr(7, 1, 'h701, 1'b1, 1'b0);
    touch(7, 2); touch(7, 0); touch(7, 3);
    req_index_i = 4'd7;
    #1 chk("inv_first_way", victim_way_o, 2);
    chk("inv_first_valid", victim_valid_o, 0);
    cyc();

    // flush, then prior hits miss
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    count_sweep(-1, n);
    chk("flush_sweep_len", n, 16);
    req_index_i = 4'd5; req_tag_i = 20'hABCDE;
    #1 chk("flush_miss", hit_o, 0);
    cyc();

    // flush during sweep is ignored
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    count_sweep(5, n);
    chk("flush_in_sweep_len", n, 16);

    // reset at sweep set 8 restarts the sweep
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    repeat (8) cyc();
    do_reset(2);
    count_sweep(-1, n);
    chk("midsweep_reset_len", n, 16);

`ifdef TAG_MEM_DIRTY_EN
    wr(9, 1, 'h12345, 1'b1, 1'b1);
    wr(9, 0, 'h900, 1'b1, 1'b0);
    wr(9, 2, 'h902, 1'b1, 1'b0);
    wr(9, 3, 'h903, 1'b1, 1'b0);
    touch(9, 0); touch(9, 2); touch(9, 3);
    req_index_i = 4'd9;
    #1 chk("dirty_victim_way", victim_way_o, 1);
    chk("dirty_victim_tag", victim_tag_o, 'h12345);
    chk("dirty_victim_dirty", victim_dirty_o, 1);
    cyc();
`endif

    // randomised traffic on a few sets to get dense hits and evictions
    for (int i = 0; i < 900; i++) begin
      req_index_i   = IDX_W'($urandom_range(0, 3));
      req_tag_i     = TAG_W'('h100 + $urandom_range(0, 7));
      wr_en_i       = ($urandom_range(0, 9) < 4);
      wr_index_i    = IDX_W'($urandom_range(0, 3));
      wr_way_i      = WAY_W'($urandom_range(0, 3));
      wr_tag_i      = TAG_W'('h100 + $urandom_range(0, 7));
      wr_valid_i    = ($urandom_range(0, 7) != 0);
`ifdef TAG_MEM_DIRTY_EN
      wr_dirty_i    = $urandom_range(0, 1) != 0;
`endif
      touch_en_i    = ($urandom_range(0, 9) < 4);
      touch_index_i = IDX_W'($urandom_range(0, 3));
      touch_way_i   = WAY_W'($urandom_range(0, 3));
      flush_i       = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) begin
        wr_en_i = 1'b0; touch_en_i = 1'b0; flush_i = 1'b0;
        do_reset(2);
      end else begin
        cyc();
      end
    end
    wr_en_i = 1'b0; touch_en_i = 1'b0; flush_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
